// File: rtl/frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_writer
//  Description : Accepts a raster-order pixel stream over valid/ready, writes
//                each pixel into the back buffer, detects frame completion and
//                requests a tear-free buffer swap at the next vblank rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_writer #(
   parameter int H_RES    = 320,
   parameter int V_RES    = 240,
   parameter int WIDTH    = 4,
   parameter int ADDR_LEN = 17
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pixel_valid,
   input  logic                pixel_first,
   input  logic [WIDTH-1:0]    pixel_data,
   output logic                pixel_ready,
   input  logic                vblank_in,
   output logic                write_enable,
   output logic [ADDR_LEN-1:0] write_addr,
   output logic [WIDTH-1:0]    write_data,
   output logic                swap_buffers,
   output logic                frame_done_out,
   output logic                frame_error_out,
   output logic [15:0]         frame_count_out
);

   localparam int                  c_pixels    = H_RES * V_RES;
   localparam logic [ADDR_LEN-1:0] c_last_addr = ADDR_LEN'(c_pixels - 1);

   localparam logic [1:0] c_st_write       = 2'd0;
   localparam logic [1:0] c_st_wait_vblank = 2'd1;
   localparam logic [1:0] c_st_swap        = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_next_state;
   logic [ADDR_LEN-1:0] r_count;
   logic                r_vb_q;
   logic                w_xfer;
   logic [ADDR_LEN-1:0] w_addr;
   logic                w_last;
   logic                w_vb_rise;

   // Handshake, effective pixel address (frame start forces 0) and vblank edge
   always_comb begin
      w_xfer    = pixel_valid && pixel_ready;
      w_addr    = pixel_first ? '0 : r_count;
      w_last    = (w_addr == c_last_addr);
      w_vb_rise = vblank_in && !r_vb_q;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_write;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: only a vblank edge seen while waiting triggers the swap
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_write: begin
            if (w_xfer && w_last) begin
               w_next_state = c_st_wait_vblank;
            end
         end
         c_st_wait_vblank: begin
            if (w_vb_rise) begin
               w_next_state = c_st_swap;
            end
         end
         c_st_swap: begin
            w_next_state = c_st_write;
         end
         default: begin
            w_next_state = c_st_write;
         end
      endcase
   end

   // State-decoded outputs: ready only while writing, swap pulse in SWAP
   always_comb begin
      pixel_ready    = 1'b0;
      swap_buffers   = 1'b0;
      frame_done_out = 1'b0;
      case (r_state)
         c_st_write: begin
            pixel_ready = 1'b1;
         end
         c_st_swap: begin
            swap_buffers   = 1'b1;
            frame_done_out = 1'b1;
         end
         default: begin
            pixel_ready = 1'b0;
         end
      endcase
   end

   // Pixel counter: wraps to 0 after the last pixel of the frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_xfer) begin
         r_count <= w_last ? '0 : (w_addr + 1'b1);
      end
   end

   // Write port: one cycle behind the handshake, address/data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_enable <= 1'b0;
         write_addr   <= '0;
         write_data   <= '0;
      end else begin
         write_enable <= w_xfer;
         if (w_xfer) begin
            write_addr <= w_addr;
            write_data <= pixel_data;
         end
      end
   end

   // Vblank delay register for edge detection, updated in every state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vb_q <= 1'b0;
      end else begin
         r_vb_q <= vblank_in;
      end
   end

   // Sticky resync error: frame start mid-frame; cleared by the swap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_error_out <= 1'b0;
      end else if (r_state == c_st_swap) begin
         frame_error_out <= 1'b0;
      end else if (w_xfer && pixel_first && (r_count != '0)) begin
         frame_error_out <= 1'b1;
      end
   end

   // Completed-frame counter, advanced once per swap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count_out <= '0;
      end else if (r_state == c_st_swap) begin
         frame_count_out <= frame_count_out + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_writer
//  Description : Scoreboard bench for frame_writer with H_RES=4, V_RES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_writer;

   logic       clk = 1'b0;
   logic       rst;
   logic       pixel_valid;
   logic       pixel_first;
   logic [3:0] pixel_data;
   logic       pixel_ready;
   logic       vblank_in;
   logic       write_enable;
   logic [2:0] write_addr;
   logic [3:0] write_data;
   logic       swap_buffers;
   logic       frame_done_out;
   logic       frame_error_out;
   logic [15:0] frame_count_out;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [2:0] addr;
      logic [3:0] data;
   } wr_t;

   wr_t          expq[$];
   logic [15:0]  swapq[$];

   frame_writer #(
      .H_RES(4), .V_RES(2), .WIDTH(4), .ADDR_LEN(3)
   ) dut (
      .clk(clk), .rst(rst),
      .pixel_valid(pixel_valid), .pixel_first(pixel_first),
      .pixel_data(pixel_data), .pixel_ready(pixel_ready),
      .vblank_in(vblank_in),
      .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .swap_buffers(swap_buffers),
      .frame_done_out(frame_done_out), .frame_error_out(frame_error_out),
      .frame_count_out(frame_count_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every write and every swap must match the next expected entry
   always @(negedge clk) begin
      if (!rst) begin
         if (write_enable) begin
            if (expq.size() == 0) begin
               chk("unexpected_write", {write_addr, write_data}, 32'hFFFF);
            end else begin
               wr_t e;
               e = expq.pop_front();
               chk("write_addr", write_addr, e.addr);
               chk("write_data", write_data, e.data);
            end
         end
         if (swap_buffers || frame_done_out) begin
            chk("swap_done_same_cycle", swap_buffers, frame_done_out);
            if (swapq.size() == 0) begin
               chk("unexpected_swap", swap_buffers, 32'd0);
            end else begin
               logic [15:0] c;
               c = swapq.pop_front();
               chk("count_at_swap", frame_count_out, c);
            end
         end
      end
   end

   task automatic send(input logic first, input logic [3:0] data, input logic [2:0] addr);
      int wait_cnt;
      wr_t e;
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_first = first;
      pixel_data  = data;
      wait_cnt = 0;
      while (!pixel_ready && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (!pixel_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
      end else begin
         e.addr = addr;
         e.data = data;
         expq.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         pixel_valid = 1'b0;
         pixel_first = 1'b0;
      end
   endtask

   // Produce a vblank rising edge and check the swap pulse one cycle later
   task automatic do_swap(input logic [15:0] count_before);
      @(negedge clk);
      pixel_valid = 1'b0;
      vblank_in   = 1'b0;
      repeat (2) @(negedge clk);
      swapq.push_back(count_before);
      vblank_in = 1'b1;
      @(negedge clk);
      chk("swap_pulse", swap_buffers, 1'b1);
      @(negedge clk);
      chk("swap_one_cycle", swap_buffers, 1'b0);
      chk("ready_after_swap", pixel_ready, 1'b1);
      chk("frame_count", frame_count_out, count_before + 16'd1);
      vblank_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pixel_valid = 1'b0;
      pixel_first = 1'b0;
      pixel_data  = 4'd0;
      vblank_in   = 1'b0;
      #1;
      chk("rst_write_enable", write_enable, 1'b0);
      chk("rst_addr_data", {write_addr, write_data}, 7'd0);
      chk("rst_swap", {swap_buffers, frame_done_out, frame_error_out}, 3'd0);
      chk("rst_count", frame_count_out, 16'd0);
      chk("rst_ready", pixel_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Frame 1: continuous stream, data 0..7
      for (int i = 0; i < 8; i++) send(i == 0, 4'(i), 3'(i));
      @(negedge clk);
      pixel_valid = 1'b0;
      chk("ready_drop", pixel_ready, 1'b0);
      repeat (20) @(negedge clk);
      chk("ready_held_low", pixel_ready, 1'b0);
      do_swap(16'd0);

      // Frame 2: completes while vblank already high
      vblank_in = 1'b1;
      for (int i = 0; i < 8; i++) send(i == 0, 4'(15 - i), 3'(i));
      idle(10);
      chk("no_swap_vblank_high", frame_count_out, 16'd1);
      do_swap(16'd1);

      // Frame 3: resync after 3 pixels
      for (int i = 0; i < 3; i++) send(i == 0, 4'(i + 1), 3'(i));
      send(1'b1, 4'd9, 3'd0);
      @(negedge clk);
      pixel_valid = 1'b0;
      chk("resync_error_set", frame_error_out, 1'b1);
      for (int i = 1; i < 8; i++) send(1'b0, 4'(i + 8), 3'(i));
      idle(1);
      chk("error_sticky", frame_error_out, 1'b1);
      do_swap(16'd2);
      chk("error_cleared", frame_error_out, 1'b0);

      // Asynchronous reset mid-frame
      for (int i = 0; i < 3; i++) send(i == 0, 4'(i + 4), 3'(i));
      #3;
      rst = 1'b1;
      pixel_valid = 1'b0;
      void'(expq.pop_back());
      #1;
      chk("async_rst_we", write_enable, 1'b0);
      chk("async_rst_addr_data", {write_addr, write_data}, 7'd0);
      chk("async_rst_count", frame_count_out, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) send(1'b0, 4'(i + 3), 3'(i));
      idle(5);
      chk("no_swap_after_rst", frame_count_out, 16'd0);
      do_swap(16'd0);

      // Two frames with gapped valid
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 8; i++) begin
            send(i == 0, 4'(f * 8 + i), 3'(i));
            idle($urandom_range(1, 3));
         end
         do_swap(16'(f + 1));
      end
      chk("final_count", frame_count_out, 16'd3);

      idle(3);
      chk("writes_drained", expq.size(), 32'd0);
      chk("swaps_drained", swapq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
